// File: rtl/usr_io_pkg.sv
// Shared types and default timing constants for the user key/switch input conditioner.
package usr_io_pkg;

  typedef enum logic [1:0] {
    KEY_RELEASED    = 2'd0,
    KEY_PRESS_DEB   = 2'd1,
    KEY_PRESSED     = 2'd2,
    KEY_RELEASE_DEB = 2'd3
  } key_state_t;

  localparam int unsigned DEB_CYC_50M  = 1_000_000;   // 20 ms at 50 MHz
  localparam int unsigned LONG_CYC_50M = 50_000_000;  // 1 s at 50 MHz

endpackage

// File: rtl/debounce_channel.sv
// One input channel: two-flop synchronizer, debounce counter and accepted (stable) level.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter logic        RST_VAL      = 1'b0
) (
  input  logic fpga_clk_50,
  input  logic fpga_rst_n,
  input  logic raw_i,
  output logic synced_o,
  output logic level_o,
  output logic expire_o
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) begin
      sync_q1  <= RST_VAL;
      sync_q2  <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      sync_q1 <= raw_i;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q2;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Expiry alone is not an accept: the caller also requires synced != level.
  assign synced_o = sync_q2;
  assign level_o  = stable_q;
  assign expire_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/usr_input_conditioner.sv
// Debounces the PIO-driven keys and switches and derives press/release/long-press/change pulses.
//
// state           | meaning
// KEY_RELEASED    | debounced level high, synced input high
// KEY_PRESS_DEB   | synced low, waiting for the debounce counter to expire
// KEY_PRESSED     | debounced level low, long-press counter running
// KEY_RELEASE_DEB | synced high again, waiting for expiry; long counter keeps running
module usr_input_conditioner
  import usr_io_pkg::*;
#(
  parameter int unsigned N_KEY          = 3,
  parameter int unsigned N_SW           = 3,
  parameter int unsigned DEBOUNCE_CYC   = DEB_CYC_50M,
  parameter int unsigned LONG_PRESS_CYC = LONG_CYC_50M
) (
  input  logic             fpga_clk_50,
  input  logic             fpga_rst_n,
  input  logic [N_KEY-1:0] key_raw_i,
  input  logic [N_SW-1:0]  sw_raw_i,
  output logic [N_KEY-1:0] key_level_o,
  output logic [N_KEY-1:0] key_press_o,
  output logic [N_KEY-1:0] key_release_o,
  output logic [N_KEY-1:0] key_long_o,
  output logic [N_SW-1:0]  sw_level_o,
  output logic [N_SW-1:0]  sw_change_o
);

  localparam int unsigned   LW        = $clog2(LONG_PRESS_CYC);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_PRESS_CYC - 1);
  localparam logic [LW-1:0] LONG_PREV = LW'(LONG_PRESS_CYC - 2);

  logic [N_KEY-1:0] key_sync;
  logic [N_KEY-1:0] key_exp;
  logic [N_SW-1:0]  sw_sync;
  logic [N_SW-1:0]  sw_exp;
  logic [N_SW-1:0]  sw_acc;

  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    key_state_t    state_q;
    logic [LW-1:0] long_cnt_q;
    logic          press_q;
    logic          release_q;
    logic          long_q;
    logic          acc;

    debounce_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .RST_VAL      (1'b1)
    ) u_deb (
      .fpga_clk_50 (fpga_clk_50),
      .fpga_rst_n  (fpga_rst_n),
      .raw_i       (key_raw_i[i]),
      .synced_o    (key_sync[i]),
      .level_o     (key_level_o[i]),
      .expire_o    (key_exp[i])
    );

    assign acc = key_exp[i] & (key_sync[i] ^ key_level_o[i]);

    always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
        state_q    <= KEY_RELEASED;
        long_cnt_q <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state_q)
          KEY_RELEASED: begin
            if (!key_sync[i]) state_q <= KEY_PRESS_DEB;
          end
          KEY_PRESS_DEB: begin
            if (acc) begin
              state_q    <= KEY_PRESSED;
              press_q    <= 1'b1;
              long_cnt_q <= '0;
            end else if (key_sync[i]) begin
              state_q <= KEY_RELEASED;
            end
          end
          KEY_PRESSED: begin
            if (key_sync[i]) state_q <= KEY_RELEASE_DEB;
          end
          KEY_RELEASE_DEB: begin
            if (acc) begin
              state_q   <= KEY_RELEASED;
              release_q <= 1'b1;
            end else if (!key_sync[i]) begin
              state_q <= KEY_PRESSED;
            end
          end
          default: state_q <= KEY_RELEASED;
        endcase
        // Saturating at LONG_LAST is what limits the long pulse to one per press.
        if ((state_q == KEY_PRESSED || state_q == KEY_RELEASE_DEB) && long_cnt_q != LONG_LAST) begin
          long_cnt_q <= long_cnt_q + LW'(1);
          if (long_cnt_q == LONG_PREV) long_q <= 1'b1;
        end
      end
    end

    assign key_press_o[i]   = press_q;
    assign key_release_o[i] = release_q;
    assign key_long_o[i]    = long_q;
  end

  for (genvar j = 0; j < N_SW; j++) begin : g_sw
    debounce_channel #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .RST_VAL      (1'b0)
    ) u_deb (
      .fpga_clk_50 (fpga_clk_50),
      .fpga_rst_n  (fpga_rst_n),
      .raw_i       (sw_raw_i[j]),
      .synced_o    (sw_sync[j]),
      .level_o     (sw_level_o[j]),
      .expire_o    (sw_exp[j])
    );
  end

  assign sw_acc = sw_exp & (sw_sync ^ sw_level_o);

  always_ff @(posedge fpga_clk_50 or negedge fpga_rst_n) begin
    if (!fpga_rst_n) sw_change_o <= '0;
    else             sw_change_o <= sw_acc;
  end

endmodule

// File: doc/usr_input_conditioner.md
# usr_input_conditioner

Conditions the three low-active key inputs and three switch inputs that the debug tool drives through the HPS PIOs before they reach the student module. Per channel: a two-flop synchronizer, then a debounce counter, then per-key press, release and long-press event pulses. Sits between the PIO exports and the student module's `usr_key_i` / `usr_sw_i` inputs. Gives student logic clean levels and single-cycle events instead of raw PIO writes.

## Interface
- `N_KEY`, 3: number of key channels, low-active.
- `N_SW`, 3: number of switch channels, high-active.
- `DEBOUNCE_CYC`, 1_000_000: cycles an input must hold a new value before it is accepted (20 ms at 50 MHz). Legal range ≥ 2.
- `LONG_PRESS_CYC`, 50_000_000: cycles a debounced key must stay pressed to raise a long-press event (1 s). Must be > `DEBOUNCE_CYC`.
- `fpga_clk_50`  in  1: single clock for the whole block.
- `fpga_rst_n`  in  1: asynchronous, active-low reset.
- `key_raw_i`  in  N_KEY: raw keys, 0 = pressed. Asynchronous to the clock.
- `sw_raw_i`  in  N_SW: raw switches. Asynchronous to the clock.
- `key_level_o`  out  N_KEY: debounced key levels, 0 = pressed.
- `key_press_o`  out  N_KEY: 1-cycle pulse on the debounced 1→0 transition.
- `key_release_o`  out  N_KEY: 1-cycle pulse on the debounced 0→1 transition.
- `key_long_o`  out  N_KEY: 1-cycle pulse, at most once per press.
- `sw_level_o`  out  N_SW: debounced switch levels.
- `sw_change_o`  out  N_SW: 1-cycle pulse on any debounced switch transition.

## Operation
- **Synchronizer.** Each input passes through two flops. Key sync flops reset to 1; switch sync flops reset to 0.
- **Debounce.** Each channel holds a stable value and a counter of width `$clog2(DEBOUNCE_CYC)`.
  - When synced ≠ stable, the counter increments.
  - When synced == stable, the counter clears to 0.
  - When the counter equals `DEBOUNCE_CYC-1` and synced still ≠ stable, the next clock loads stable ← synced and clears the counter.
- **Key FSM.** One FSM per key, with states RELEASED, PRESS_DEB, PRESSED, RELEASE_DEB.
  - RELEASED→PRESS_DEB when synced = 0.
  - PRESS_DEB→RELEASED on a bounce (synced = 1).
  - PRESS_DEB→PRESSED on counter expiry; assert `key_press_o` and clear the long counter.
  - PRESSED→RELEASE_DEB when synced = 1.
  - RELEASE_DEB→PRESSED on a bounce. The long counter keeps running.
  - RELEASE_DEB→RELEASED on counter expiry; assert `key_release_o`.
- **Long press.**
  - The long counter (width `$clog2(LONG_PRESS_CYC)`) counts while in PRESSED or RELEASE_DEB.
  - It saturates at `LONG_PRESS_CYC-1`.
  - `key_long_o` pulses on the cycle the counter reaches `LONG_PRESS_CYC-1`, so exactly once per press.
  - If the key is released before that point, no long pulse is produced.
- **Switches.** Same debounce path with no FSM. `sw_change_o` pulses on the cycle `sw_level_o` changes.
- **Independence.** Channels are fully independent. Simultaneous events on different channels all pulse in the same cycle.
- **Reset.**
  - Asserting reset mid-debounce or mid-press aborts the operation silently; no release pulse is produced.
  - Reset values: `key_level_o` all 1, `sw_level_o` all 0, every pulse output 0, FSMs RELEASED, all counters 0.
- **Switches high at reset.** A switch held high through reset produces one `sw_change_o` pulse after release of reset plus 2 + `DEBOUNCE_CYC` cycles. This is required behaviour.

## Timing
- All outputs are registered.
- Latency from a raw edge that then stays stable to the level/pulse output is 2 + `DEBOUNCE_CYC` rising edges.
- Each pulse is asserted in the same cycle its level output changes.
- `key_long_o` is asserted `LONG_PRESS_CYC-1` cycles after `key_press_o`, provided the key is not released.
- A bounce shorter than `DEBOUNCE_CYC` synced cycles produces no output change.

## Structure
- **Package `usr_io_pkg`:**
  - key FSM state enum (`KEY_RELEASED`, `KEY_PRESS_DEB`, `KEY_PRESSED`, `KEY_RELEASE_DEB`);
  - default constants `DEB_CYC_50M` and `LONG_CYC_50M`.
- **Sub-module `debounce_channel`:** synchronizer, debounce counter and stable register, parameterised on reset value and `DEBOUNCE_CYC`.
  - Instantiated N_KEY + N_SW times via generate.
  - The key FSM and long counter live in the top of the block.

## Test plan
All scenarios use `DEBOUNCE_CYC` = 4 and `LONG_PRESS_CYC` = 12.
- **Reset values.** Assert reset, then release it with all keys at 1 and all switches at 0 → `key_level_o` = 3'b111, `sw_level_o` = 0, no pulses for 50 cycles.
- **Clean press and release.** `key_raw_i[0]` goes to 0 for 8 cycles, then back to 1 → press pulse 6 cycles after the fall; release pulse 6 cycles after the rise; no `key_long_o`.
- **Bounce rejection.** Toggle `key_raw_i[1]` 0/1 every 2 cycles for 20 cycles, then hold at 1 → no outputs on any key. Then hold at 0 → exactly one press pulse.
- **Long press.** Hold `key_raw_i[2]` at 0 for 30 cycles → `key_press_o[2]` fires, then `key_long_o[2]` exactly 11 cycles later and only once. Release gives one release pulse.
- **Simultaneous events.** Change `sw_raw_i` to 3'b101 in the same cycle `key_raw_i[0]` falls → `sw_change_o` = 3'b101 and `key_press_o[0]` in the same cycle.
- **Reset mid-press.** Assert reset during PRESSED → outputs return to reset values immediately; no release pulse appears afterwards.
